// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-file target.
// FSM encoding, R/W bit values and the default glitch-filter length.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK,
    ST_IGNORE
  } i2c_target_state_t;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  localparam int I2C_FILTER_LEN = 3;

endpackage

// File: rtl/i2c_target_regfile_if.sv
// Raw bus lines plus the filtered event bundle between the bus filter
// (master: produces events) and the target FSM (slave: consumes them).
interface i2c_target_regfile_if;

  logic scl;
  logic sda;
  logic scl_rise;
  logic scl_fall;
  logic start;
  logic stop;
  logic sda_f;

  modport master (
    input  scl, sda,
    output scl_rise, scl_fall, start, stop, sda_f
  );

  modport slave (
    output scl, sda,
    input  scl_rise, scl_fall, start, stop, sda_f
  );

endinterface

// File: rtl/i2c_bus_filter.sv
// Synchroniser, FILTER_LEN-sample glitch filter and START/STOP/edge
// detection for SCL and SDA.
module i2c_bus_filter
  import i2c_pkg::*;
#(
  parameter int FILTER_LEN = I2C_FILTER_LEN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  i2c_target_regfile_if.master bus
);

  localparam int HW = FILTER_LEN - 1;

  logic [1:0]            scl_s_q, sda_s_q;
  logic [HW-1:0]         scl_h_q, sda_h_q;
  logic [FILTER_LEN-1:0] scl_win, sda_win;
  logic                  scl_f_q, sda_f_q;
  logic                  scl_p_q, sda_p_q;

  // Window = history plus the newest synchronised sample.
  assign scl_win = {scl_h_q, scl_s_q[1]};
  assign sda_win = {sda_h_q, sda_s_q[1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s_q <= '1;
      sda_s_q <= '1;
      scl_h_q <= '1;
      sda_h_q <= '1;
      scl_f_q <= 1'b1;
      sda_f_q <= 1'b1;
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_s_q <= {scl_s_q[0], bus.scl};
      sda_s_q <= {sda_s_q[0], bus.sda};
      scl_h_q <= scl_win[HW-1:0];
      sda_h_q <= sda_win[HW-1:0];
      if (&scl_win)       scl_f_q <= 1'b1;
      else if (~|scl_win) scl_f_q <= 1'b0;
      if (&sda_win)       sda_f_q <= 1'b1;
      else if (~|sda_win) sda_f_q <= 1'b0;
      scl_p_q <= scl_f_q;
      sda_p_q <= sda_f_q;
    end
  end

  assign bus.sda_f    = sda_f_q;
  assign bus.scl_rise = scl_f_q & ~scl_p_q;
  assign bus.scl_fall = ~scl_f_q & scl_p_q;
  assign bus.start    = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
  assign bus.stop     = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target owning a small register file with an auto-incrementing
// pointer, plus a local read port and write-event strobe.
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int I2C_DATA_WIDTH = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDRESS = 7'h22,
  parameter int NUM_REGS   = 16,
  parameter int FILTER_LEN = I2C_FILTER_LEN,
  localparam int PTR_W = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      sda_oe_o,
  output logic                      wr_strobe_o,
  output logic [PTR_W-1:0]          wr_addr_o,
  output logic [I2C_DATA_WIDTH-1:0] wr_data_o,
  input  logic [PTR_W-1:0]          rd_addr_i,
  output logic [I2C_DATA_WIDTH-1:0] rd_data_o,
  output logic                      busy_o,
  output logic                      xfer_done_o
);

  localparam int DW = I2C_DATA_WIDTH;
  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);
  localparam logic [CW-1:0] FULL = CW'(DW);

  i2c_target_regfile_if bus ();

  assign bus.scl = scl_i;
  assign bus.sda = sda_i;

  i2c_bus_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  i2c_target_state_t state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-2:0]    sh_q, sh_d;
  logic [DW-1:0]    tx_q, tx_d, rx_byte;
  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc;
  logic [DW-1:0]    regs_q [NUM_REGS];
  logic             oe_q, oe_d;
  logic             busy_q, busy_d;
  logic             rw_q, rw_d;
  logic             done_q, done_d;
  logic             we;
  logic             wr_strobe_q;
  logic [PTR_W-1:0] wr_addr_q;
  logic [DW-1:0]    wr_data_q, rd_data_q;

  assign rx_byte = {sh_q, bus.sda_f};
  assign ptr_inc = ptr_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    ptr_d   = ptr_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    rw_d    = rw_q;
    done_d  = 1'b0;
    we      = 1'b0;
    if (bus.stop) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = busy_q;
    end else if (bus.start) begin
      state_d = ST_ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
    end else begin
      if (bus.scl_rise) begin
        sh_d  = rx_byte[DW-2:0];
        cnt_d = cnt_q + 1'b1;
      end
      unique case (state_q)
        ST_ADDR: begin
          if (bus.scl_rise && cnt_q == LAST) begin
            cnt_d = '0;
            if (rx_byte[DW-1 -: I2C_ADDR_WIDTH] == SLAVE_ADDRESS) begin
              state_d = ST_ADDR_ACK;
              busy_d  = 1'b1;
              rw_d    = rx_byte[0];
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        // First fall starts the ACK, second fall ends it.
        ST_ADDR_ACK: begin
          if (bus.scl_fall) begin
            cnt_d = '0;
            if (!oe_q) begin
              oe_d = 1'b1;
            end else if (rw_q == I2C_RW_READ) begin
              state_d = ST_RDATA;
              tx_d    = regs_q[ptr_q];
              oe_d    = ~regs_q[ptr_q][DW-1];
            end else begin
              state_d = ST_PTR;
              oe_d    = 1'b0;
            end
          end
        end
        ST_PTR: begin
          if (bus.scl_rise && cnt_q == LAST) begin
            ptr_d   = rx_byte[PTR_W-1:0];
            state_d = ST_PTR_ACK;
            cnt_d   = '0;
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (bus.scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d    = 1'b0;
              state_d = ST_WDATA;
              cnt_d   = '0;
            end
          end
        end
        ST_WDATA: begin
          if (bus.scl_rise && cnt_q == LAST) begin
            we      = 1'b1;
            ptr_d   = ptr_inc;
            state_d = ST_WDATA_ACK;
            cnt_d   = '0;
          end
        end
        ST_RDATA: begin
          if (bus.scl_fall) begin
            if (cnt_q == FULL) begin
              state_d = ST_RACK;
              oe_d    = 1'b0;
              cnt_d   = '0;
            end else begin
              tx_d = tx_q << 1;
              oe_d = ~tx_q[DW-2];
            end
          end
        end
        // cnt_q != 0 marks a sampled master ACK awaiting the next fall.
        ST_RACK: begin
          if (bus.scl_rise) begin
            if (bus.sda_f) begin
              state_d = ST_IGNORE;
              cnt_d   = '0;
            end else begin
              ptr_d = ptr_inc;
              tx_d  = regs_q[ptr_inc];
              cnt_d = CW'(1);
            end
          end else if (bus.scl_fall && cnt_q != '0) begin
            state_d = ST_RDATA;
            oe_d    = ~tx_q[DW-1];
            cnt_d   = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      tx_q        <= '0;
      ptr_q       <= '0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      rw_q        <= 1'b0;
      done_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_data_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      tx_q        <= tx_d;
      ptr_q       <= ptr_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      rw_q        <= rw_d;
      done_q      <= done_d;
      wr_strobe_q <= we;
      rd_data_q   <= regs_q[rd_addr_i];
      if (we) begin
        regs_q[ptr_q] <= rx_byte;
        wr_addr_q     <= ptr_q;
        wr_data_q     <= rx_byte;
      end
    end
  end

  assign sda_oe_o    = oe_q;
  assign busy_o      = busy_q;
  assign xfer_done_o = done_q;
  assign wr_strobe_o = wr_strobe_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign rd_data_o   = rd_data_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged I2C master, strobe and
// read-data scoreboards, register model checked through the local port.
`timescale 1ns/1ps
module tb_i2c_target_regfile;

  localparam int HP = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic [3:0] rd_addr = '0;
  logic       sda_oe, wr_strobe, busy, done;
  logic [3:0] wr_addr;
  logic [7:0] wr_data, rd_data;

  i2c_target_regfile_if bus ();

  assign bus.scl = m_scl;
  assign bus.sda = m_sda & ~sda_oe;

  i2c_target_regfile dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scl_i       (bus.scl),
    .sda_i       (bus.sda),
    .sda_oe_o    (sda_oe),
    .wr_strobe_o (wr_strobe),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data),
    .busy_o      (busy),
    .xfer_done_o (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [11:0] exp_wr[$];
  logic [11:0] obs_wr[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  model [16];
  int   done_cnt = 0;
  logic oe_seen = 1'b0;
  logic busy_seen = 1'b0;

  always @(negedge clk) begin
    if (wr_strobe) obs_wr.push_back({wr_addr, wr_data});
    if (done) done_cnt++;
    if (sda_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; clks(HP/2);
    m_scl = 1'b1; clks(HP);
    m_sda = 1'b0; clks(HP);
    m_scl = 1'b0; clks(HP/2);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; clks(HP/2);
    m_scl = 1'b1; clks(HP);
    m_sda = 1'b1; clks(HP);
  endtask

  task automatic bit_w(input logic b);
    m_sda = b;    clks(HP/2);
    m_scl = 1'b1; clks(HP);
    m_scl = 1'b0; clks(HP/2);
  endtask

  task automatic bit_r(output logic b);
    m_sda = 1'b1; clks(HP/2);
    m_scl = 1'b1; clks(HP/2);
    b = bus.sda;  clks(HP/2);
    m_scl = 1'b0; clks(HP/2);
  endtask

  task automatic byte_w(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) bit_w(d[i]);
    bit_r(ack);
  endtask

  task automatic byte_r(output logic [7:0] d, input logic ack);
    for (int i = 7; i >= 0; i--) bit_r(d[i]);
    bit_w(ack);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clks(3);
    @(negedge clk);
    checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", sda_oe); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({wr_strobe, done} !== 2'b00) begin failures++; $display("FAIL reset_pulses got=%b exp=00", {wr_strobe, done}); end
    checks++; if ({wr_addr, wr_data} !== 12'h000) begin failures++; $display("FAIL reset_wr got=%h exp=000", {wr_addr, wr_data}); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd got=%h exp=00", rd_data); end
    rst_n = 1'b1;
    clks(10);
  endtask

  task automatic test_write_burst();
    logic ack;
    done_cnt = 0;
    i2c_start();
    byte_w(8'h44, ack);
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL wb_addr_ack got=%b exp=0", ack); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wb_busy got=%b exp=1", busy); end
    byte_w(8'h03, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL wb_ptr_ack got=%b exp=0", ack); end
    exp_wr.push_back({4'h3, 8'hA5}); model[3] = 8'hA5;
    byte_w(8'hA5, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL wb_d0_ack got=%b exp=0", ack); end
    exp_wr.push_back({4'h4, 8'h5A}); model[4] = 8'h5A;
    byte_w(8'h5A, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL wb_d1_ack got=%b exp=0", ack); end
    i2c_stop();
    clks(10);
    @(negedge clk);
    while (exp_wr.size() > 0) begin
      logic [11:0] e;
      e = exp_wr.pop_front();
      checks++;
      if (obs_wr.size() == 0) begin failures++; $display("FAIL wb_strobe got=none exp=%h", e); end
      else begin
        logic [11:0] o;
        o = obs_wr.pop_front();
        if (o !== e) begin failures++; $display("FAIL wb_strobe got=%h exp=%h", o, e); end
      end
    end
    checks++; if (obs_wr.size() != 0) begin failures++; $display("FAIL wb_extra_strobes got=%0d exp=0", obs_wr.size()); obs_wr.delete(); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL wb_done got=%0d exp=1", done_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wb_busy_after got=%b exp=0", busy); end
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      @(posedge clk); @(negedge clk);
      checks++; if (rd_data !== model[a]) begin failures++; $display("FAIL wb_reg%0d got=%h exp=%h", a, rd_data, model[a]); end
    end
  endtask

  task automatic test_rstart_read();
    logic ack;
    logic [7:0] d, e;
    done_cnt = 0;
    i2c_start();
    byte_w(8'h44, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL rd_waddr_ack got=%b exp=0", ack); end
    byte_w(8'h03, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL rd_ptr_ack got=%b exp=0", ack); end
    i2c_start();
    byte_w(8'h45, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL rd_raddr_ack got=%b exp=0", ack); end
    exp_rd.push_back(model[3]);
    exp_rd.push_back(model[4]);
    byte_r(d, 1'b0);
    e = exp_rd.pop_front();
    checks++; if (d !== e) begin failures++; $display("FAIL rd_byte0 got=%h exp=%h", d, e); end
    byte_r(d, 1'b1);
    e = exp_rd.pop_front();
    checks++; if (d !== e) begin failures++; $display("FAIL rd_byte1 got=%h exp=%h", d, e); end
    clks(HP);
    @(negedge clk);
    checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL rd_release got=%b exp=0", sda_oe); end
    i2c_stop();
    clks(10);
    checks++; if (obs_wr.size() != 0) begin failures++; $display("FAIL rd_strobes got=%0d exp=0", obs_wr.size()); obs_wr.delete(); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL rd_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_mismatch();
    logic ack;
    done_cnt = 0;
    oe_seen = 1'b0;
    busy_seen = 1'b0;
    i2c_start();
    byte_w(8'h46, ack);
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL mm_addr_ack got=%b exp=1", ack); end
    byte_w(8'h00, ack);
    byte_w(8'hFF, ack);
    i2c_stop();
    clks(10);
    checks++; if (oe_seen !== 1'b0) begin failures++; $display("FAIL mm_oe got=%b exp=0", oe_seen); end
    checks++; if (busy_seen !== 1'b0) begin failures++; $display("FAIL mm_busy got=%b exp=0", busy_seen); end
    checks++; if (obs_wr.size() != 0) begin failures++; $display("FAIL mm_strobes got=%0d exp=0", obs_wr.size()); obs_wr.delete(); end
    checks++; if (done_cnt != 0) begin failures++; $display("FAIL mm_done got=%0d exp=0", done_cnt); end
  endtask

  task automatic test_wrap();
    logic ack;
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    i2c_start();
    byte_w(8'h44, ack);
    byte_w(8'h0F, ack);
    for (int i = 0; i < 3; i++) begin
      logic [3:0] a;
      a = 4'(15 + i);
      exp_wr.push_back({a, vals[i]});
      model[a] = vals[i];
      byte_w(vals[i], ack);
      checks++; if (ack !== 1'b0) begin failures++; $display("FAIL wr_ack%0d got=%b exp=0", i, ack); end
    end
    i2c_stop();
    clks(10);
    while (exp_wr.size() > 0) begin
      logic [11:0] e;
      e = exp_wr.pop_front();
      checks++;
      if (obs_wr.size() == 0) begin failures++; $display("FAIL wrap_strobe got=none exp=%h", e); end
      else begin
        logic [11:0] o;
        o = obs_wr.pop_front();
        if (o !== e) begin failures++; $display("FAIL wrap_strobe got=%h exp=%h", o, e); end
      end
    end
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      @(posedge clk); @(negedge clk);
      checks++; if (rd_data !== model[a]) begin failures++; $display("FAIL wrap_reg%0d got=%h exp=%h", a, rd_data, model[a]); end
    end
  endtask

  task automatic test_reset_mid_read();
    logic ack;
    logic [7:0] d, e;
    int n;
    i2c_start();
    byte_w(8'h45, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL rmr_addr_ack got=%b exp=0", ack); end
    n = 0;
    while (sda_oe !== 1'b1 && n < 4*HP) begin @(negedge clk); n++; end
    checks++; if (sda_oe !== 1'b1) begin failures++; $display("FAIL rmr_drive got=%b exp=1", sda_oe); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL rmr_async_release got=%b exp=0", sda_oe); end
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    exp_wr.delete(); obs_wr.delete();
    clks(3);
    rst_n = 1'b1;
    m_sda = 1'b1; clks(HP);
    m_scl = 1'b1; clks(HP);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      @(posedge clk); @(negedge clk);
      checks++; if (rd_data !== model[a]) begin failures++; $display("FAIL rmr_reg%0d got=%h exp=%h", a, rd_data, model[a]); end
    end
    i2c_start();
    byte_w(8'h45, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL rmr_raddr_ack got=%b exp=0", ack); end
    exp_rd.push_back(model[0]);
    byte_r(d, 1'b1);
    e = exp_rd.pop_front();
    checks++; if (d !== e) begin failures++; $display("FAIL rmr_byte got=%h exp=%h", d, e); end
    i2c_stop();
    clks(10);
  endtask

  task automatic test_glitch();
    logic ack;
    logic [7:0] d;
    d = 8'hC3;
    done_cnt = 0;
    i2c_start();
    byte_w(8'h44, ack);
    byte_w(8'h06, ack);
    exp_wr.push_back({4'h6, d});
    model[6] = d;
    m_sda = d[7]; clks(HP/2);
    m_scl = 1'b1; clks(HP/2);
    @(negedge clk); m_sda = 1'b0;
    @(negedge clk); m_sda = 1'b1;
    clks(HP/2);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL gl_busy got=%b exp=1", busy); end
    m_scl = 1'b0; clks(HP/2);
    for (int i = 6; i >= 0; i--) bit_w(d[i]);
    bit_r(ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL gl_data_ack got=%b exp=0", ack); end
    i2c_stop();
    clks(10);
    while (exp_wr.size() > 0) begin
      logic [11:0] e;
      e = exp_wr.pop_front();
      checks++;
      if (obs_wr.size() == 0) begin failures++; $display("FAIL gl_strobe got=none exp=%h", e); end
      else begin
        logic [11:0] o;
        o = obs_wr.pop_front();
        if (o !== e) begin failures++; $display("FAIL gl_strobe got=%h exp=%h", o, e); end
      end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL gl_done got=%0d exp=1", done_cnt); end
    rd_addr = 4'h6;
    @(posedge clk); @(negedge clk);
    checks++; if (rd_data !== model[6]) begin failures++; $display("FAIL gl_reg6 got=%h exp=%h", rd_data, model[6]); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    test_reset();
    test_write_burst();
    test_rstart_read();
    test_mismatch();
    test_wrap();
    test_reset_mid_read();
    test_glitch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
